// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
// slave modport: the unit itself; master modport: the core plus attached memory.
// Ports: req_* handshake in, resp_* result out, memory strobes/address/data out, r_data_mem in.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] data_addr;
    logic [31:0] w_data_mem;
    logic        r_en_mem;
    logic        w_en_mem;
    logic [1:0]  byte_sel;
    logic [31:0] r_data_mem;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, r_data_mem,
        output req_ready, resp_valid, resp_rdata, resp_err,
               data_addr, w_data_mem, r_en_mem, w_en_mem, byte_sel
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, r_data_mem,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               data_addr, w_data_mem, r_en_mem, w_en_mem, byte_sel
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one request -> one single-cycle memory access -> one response pulse.
// Latency: transfer at edge N, strobe in cycle N..N+1, resp_valid in cycle N+1..N+2.
// Backpressure: req_ready drops for the access cycle only; peak one access every 2 cycles.
// Ports: clk, rst (async active-low), bus (mem_access_unit_if.slave: req_*, resp_*, memory side).
// Optional: define MEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors.
module mem_access_unit #(
    parameter int unsigned DROM_SPACE = 1024
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic        r_err;
    logic [31:0] r_data_addr;
    logic [31:0] r_w_data_mem;
    logic [1:0]  r_byte_sel;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_req_ready;
    logic        w_xfer;
    logic        w_access;
    logic        w_resp_valid;
    logic [32:0] w_size;
    logic [32:0] w_last_byte;
    logic        w_f3_bad;
    logic        w_range_bad;
    logic        w_misalign;
    logic        w_err;
    logic [31:0] w_ext_rdata;

    assign w_req_ready = (r_state != S_ACCESS);
    assign w_xfer      = bus.req_valid & w_req_ready;

    // Request checks, evaluated on the raw request so the error is known before the access.
    always_comb begin
        w_size = 33'd4;
        case (bus.req_funct3[1:0])
            2'b00:   w_size = 33'd1;
            2'b01:   w_size = 33'd2;
            default: w_size = 33'd4;
        endcase
        // 33-bit sum so an access near 0xFFFFFFFF cannot wrap back into range.
        w_last_byte = {1'b0, bus.req_addr} + w_size - 33'd1;
        w_range_bad = (w_last_byte >= 33'(DROM_SPACE));

        if (bus.req_we)
            w_f3_bad = (bus.req_funct3 > 3'd2);
        else
            w_f3_bad = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);

`ifdef MEM_MISALIGN_TRAP_EN
        w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        w_misalign = 1'b0;
`endif
        w_err = w_f3_bad | w_range_bad | w_misalign;
    end

    // Load data extension from the latched funct3.
    always_comb begin
        w_ext_rdata = bus.r_data_mem;
        case (r_funct3)
            3'b000:  w_ext_rdata = {{24{bus.r_data_mem[7]}},  bus.r_data_mem[7:0]};
            3'b100:  w_ext_rdata = {24'd0,                    bus.r_data_mem[7:0]};
            3'b001:  w_ext_rdata = {{16{bus.r_data_mem[15]}}, bus.r_data_mem[15:0]};
            3'b101:  w_ext_rdata = {16'd0,                    bus.r_data_mem[15:0]};
            default: w_ext_rdata = bus.r_data_mem;
        endcase
    end

    // FSM next state and state-derived controls.
    always_comb begin
        w_state_nxt  = r_state;
        w_access     = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                w_access    = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_resp_valid = 1'b1;
                w_state_nxt  = w_xfer ? S_ACCESS : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Request latch. Memory-side address/data/size only change for accesses that will
    // actually strobe, so they hold their last legal values across errors and idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_err        <= 1'b0;
            r_data_addr  <= 32'd0;
            r_w_data_mem <= 32'd0;
            r_byte_sel   <= 2'b00;
        end else if (w_xfer) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_err    <= w_err;
            if (!w_err) begin
                r_data_addr  <= bus.req_addr;
                r_w_data_mem <= bus.req_wdata;
                r_byte_sel   <= bus.req_funct3[1:0];
            end
        end
    end

    // Response capture at the end of the access cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else if (w_access) begin
            r_resp_err   <= r_err;
            r_resp_rdata <= (r_err || r_we) ? 32'd0 : w_ext_rdata;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.r_en_mem   = w_access & ~r_err & ~r_we;
    assign bus.w_en_mem   = w_access & ~r_err &  r_we;
    assign bus.data_addr  = r_data_addr;
    assign bus.w_data_mem = r_w_data_mem;
    assign bus.byte_sel   = r_byte_sel;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory, request-level reference model,
// per-cycle compare of strobes/handshake/response, directed literal cases and random traffic.
module tb_mem_access_unit;

    localparam int MEMSZ = 1024;

    logic clk;
    logic rst;
    mem_access_unit_if bif();

    mem_access_unit #(.DROM_SPACE(MEMSZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'((k * 37) ^ 8'h5A);
    endfunction

    // ---------------- attached memory (environment) ----------------
    logic [7:0] mem [MEMSZ];
    logic       mem_init = 1'b0;

    always_comb begin
        bif.r_data_mem = '0;
        for (int k = 0; k < 4; k++)
            if (({1'b0, bif.data_addr} + 33'(k)) < 33'(MEMSZ))
                bif.r_data_mem[8*k +: 8] = mem[bif.data_addr[9:0] + 10'(k)];
    end

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < MEMSZ; k++) mem[k] <= pat(k);
            mem_init <= 1'b1;
        end else if (bif.w_en_mem) begin
            for (int k = 0; k < 4; k++)
                if (k < (bif.byte_sel == 2'b00 ? 1 : bif.byte_sel == 2'b01 ? 2 : 4) &&
                    ({1'b0, bif.data_addr} + 33'(k)) < 33'(MEMSZ))
                    mem[bif.data_addr[9:0] + 10'(k)] <= bif.w_data_mem[8*k +: 8];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic [7:0]  ref_mem [MEMSZ];
    exp_t        expq [$];

    // Expected memory activity for the cycle following a transfer.
    logic        pend_chk = 1'b0;
    logic        pend_r, pend_w;
    logic [31:0] pend_addr, pend_wd;
    logic [1:0]  pend_bs;
    logic        prev_acc = 1'b0;

    task automatic model_xfer(input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   sz;
        logic bad;
        logic [31:0] raw;
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if (longint'(a) + longint'(sz) - 1 >= longint'(MEMSZ)) bad = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
        if (sz == 2 && a[0]) bad = 1'b1;
        if (sz == 4 && a[1:0] != 2'b00) bad = 1'b1;
`endif
        e.err   = bad;
        e.rdata = 32'd0;
        if (!bad) begin
            if (we) begin
                for (int k = 0; k < sz; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
            end else begin
                raw = 32'd0;
                for (int k = 0; k < sz; k++) raw[8*k +: 8] = ref_mem[int'(a) + k];
                case (f3)
                    3'd0: e.rdata = (raw[7]  ? 32'hFFFFFF00 : 32'd0) | raw;
                    3'd1: e.rdata = (raw[15] ? 32'hFFFF0000 : 32'd0) | raw;
                    default: e.rdata = raw;
                endcase
            end
        end
        expq.push_back(e);
        pend_chk  = 1'b1;
        pend_r    = !bad && !we;
        pend_w    = !bad && we;
        pend_addr = a;
        pend_wd   = wd;
        pend_bs   = f3[1:0];
    endtask

    // ---------------- per-cycle compare ----------------
    int          resp_count = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    always @(negedge clk) begin
        if (rst && mem_init) begin
            chk("rw_exclusive", 32'(bif.r_en_mem & bif.w_en_mem), 32'd0);
            if (pend_chk) begin
                chk("r_en_mem", 32'(bif.r_en_mem), 32'(pend_r));
                chk("w_en_mem", 32'(bif.w_en_mem), 32'(pend_w));
                chk("ready_in_access", 32'(bif.req_ready), 32'd0);
                if (pend_r || pend_w) begin
                    chk("data_addr", bif.data_addr, pend_addr);
                    chk("byte_sel", 32'(bif.byte_sel), 32'(pend_bs));
                end
                if (pend_w) chk("w_data_mem", bif.w_data_mem, pend_wd);
            end else begin
                chk("idle_strobes", 32'({bif.r_en_mem, bif.w_en_mem}), 32'd0);
            end
            chk("resp_valid_timing", 32'(bif.resp_valid), 32'(prev_acc));
            if (bif.resp_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("resp_err", 32'(bif.resp_err), 32'(e.err));
                    chk("resp_rdata", bif.resp_rdata, e.rdata);
                end
                last_rdata = bif.resp_rdata;
                last_err   = bif.resp_err;
                resp_count++;
            end
            prev_acc = pend_chk;
            pend_chk = 1'b0;
        end
    end

    // ---------------- driver ----------------
    // Called in the posedge+1 phase; returns in the posedge+1 phase after the transfer edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output time t_xfer);
        int n;
        bif.req_valid  = 1'b1;
        bif.req_we     = we;
        bif.req_funct3 = f3;
        bif.req_addr   = a;
        bif.req_wdata  = wd;
        n = 0;
        while (!bif.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!bif.req_ready) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        t_xfer = $time;
        model_xfer(we, f3, a, wd);
        #1;
        bif.req_valid  = 1'b0;
        bif.req_addr   = $urandom;   // junk while not ready must be ignored
        bif.req_we     = 1'($urandom);
        bif.req_funct3 = 3'($urandom);
    endtask

    task automatic req_wait(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
        int  rc, n;
        time t;
        rc = resp_count;
        issue(we, f3, a, wd, t);
        n = 0;
        while (resp_count == rc && n < 10) begin
            @(negedge clk); #1; n++;
        end
        if (resp_count == rc) chk("resp_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        time tx [4];
        time t;
        int  n;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        for (int k = 0; k < MEMSZ; k++) ref_mem[k] = pat(k);
        rst            = 1'b0;
        bif.req_valid  = 1'b0;
        bif.req_we     = 1'b0;
        bif.req_funct3 = 3'd0;
        bif.req_addr   = 32'd0;
        bif.req_wdata  = 32'd0;

        #3;
        chk("rst_req_ready", 32'(bif.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bif.resp_valid), 32'd0);
        chk("rst_resp_rdata", bif.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bif.resp_err), 32'd0);
        chk("rst_strobes", 32'({bif.r_en_mem, bif.w_en_mem}), 32'd0);
        chk("rst_data_addr", bif.data_addr, 32'd0);
        chk("rst_w_data_mem", bif.w_data_mem, 32'd0);
        chk("rst_byte_sel", 32'(bif.byte_sel), 32'd0);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-computed results.
        req_wait(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_err", 32'(last_err), 32'd0);
        req_wait(1'b0, 3'b010, 32'h10, 32'd0);
        chk("lw_0x10", last_rdata, 32'hDEADBEEF);
        chk("lw_0x10_err", 32'(last_err), 32'd0);
        req_wait(1'b1, 3'b000, 32'h20, 32'h00000080);
        req_wait(1'b0, 3'b000, 32'h20, 32'd0);
        chk("lb_0x20", last_rdata, 32'hFFFFFF80);
        req_wait(1'b0, 3'b100, 32'h20, 32'd0);
        chk("lbu_0x20", last_rdata, 32'h00000080);
        req_wait(1'b1, 3'b001, 32'h30, 32'h00008001);
        req_wait(1'b0, 3'b001, 32'h30, 32'd0);
        chk("lh_0x30", last_rdata, 32'hFFFF8001);
        req_wait(1'b0, 3'b101, 32'h30, 32'd0);
        chk("lhu_0x30", last_rdata, 32'h00008001);
        req_wait(1'b0, 3'b010, 32'd1021, 32'd0);
        chk("lw_1021_err", 32'(last_err), 32'd1);
        chk("lw_1021_rdata", last_rdata, 32'd0);
        req_wait(1'b0, 3'b010, 32'd1020, 32'd0);
        chk("lw_1020_err", 32'(last_err), 32'd0);
        req_wait(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0);
        chk("lw_wrap_err", 32'(last_err), 32'd1);
        req_wait(1'b0, 3'b011, 32'h10, 32'd0);
        chk("ld_f3_011_err", 32'(last_err), 32'd1);
        req_wait(1'b1, 3'b100, 32'h40, 32'h12345678);
        chk("st_f3_100_err", 32'(last_err), 32'd1);

        // Back-to-back loads with valid held: one transfer every 2 cycles.
        issue(1'b0, 3'b010, 32'h10, 32'd0, tx[0]);
        issue(1'b0, 3'b000, 32'h20, 32'd0, tx[1]);
        issue(1'b0, 3'b001, 32'h30, 32'd0, tx[2]);
        issue(1'b0, 3'b010, 32'h10, 32'd0, tx[3]);
        for (int i = 1; i < 4; i++)
            chk("b2b_spacing", 32'(tx[i] - tx[i-1]), 32'd20);
        repeat (4) @(posedge clk); #1;

        // Reset while the access is in flight.
        issue(1'b0, 3'b010, 32'h10, 32'd0, t);
        #1;
        rst      = 1'b0;
        pend_chk = 1'b0;
        prev_acc = 1'b0;
        expq.delete();
        #1;
        chk("abort_strobes", 32'({bif.r_en_mem, bif.w_en_mem}), 32'd0);
        chk("abort_resp_valid", 32'(bif.resp_valid), 32'd0);
        chk("abort_req_ready", 32'(bif.req_ready), 32'd1);
        @(negedge clk);
        chk("abort_resp_valid_2", 32'(bif.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(bif.req_ready), 32'd1);
        req_wait(1'b0, 3'b001, 32'h31, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("lh_0x31_err", 32'(last_err), 32'd1);
`else
        chk("lh_0x31_err", 32'(last_err), 32'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            we = 1'($urandom);
            f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = $urandom_range(0, MEMSZ - 1);
                6, 7:             a = 32'(MEMSZ - 8 + $urandom_range(0, 7));
                8:                a = 32'hFFFFFFF0 + $urandom_range(0, 15);
                default:          a = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
            issue(we, f3, a, $urandom, t);
        end

        n = 0;
        while (expq.size() != 0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
